// File: rtl/reg_file_pkg.sv
// Shared types and constants for the parametrised architectural register file.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

    localparam int RF_ZERO_ADDR = 0;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks every register address once, then holds READY.
// Latency: NREG edges after reset release; busy is a registered state decode.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    output logic          busy,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    rf_state_t     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                ptr_d = ptr_q + AW'(1);
                if (ptr_q == AW'(NREG - 1)) begin
                    state_d = READY;
                    ptr_d   = '0;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q == CLEAR);
    // No array write on an edge that samples rst, even mid-sweep.
    assign clr_en   = busy && !rst;
    assign clr_addr = ptr_q;

endmodule

// File: rtl/reg_file_bank.sv
// Architectural register file: NRD combinational read ports, one write port,
// optional hardwired x0 and write-to-read bypass, zeroed by a sweep after reset.
module reg_file_bank
    import reg_file_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic                busy
);

    logic [XLEN-1:0] mem_q [NREG];

    logic            clr_en;
    logic [AW-1:0]   clr_addr;
    logic            wr_acc;
    logic            mem_we_d;
    logic [AW-1:0]   mem_wa_d;
    logic [XLEN-1:0] mem_wd_d;

    reg_file_clear_seq #(
        .NREG (NREG)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .busy     (busy),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // A user write is only real in READY, outside reset, and not aimed at a hardwired x0.
    assign wr_acc = we && !rst && !busy &&
                    !(ZERO_REG && (wa == AW'(RF_ZERO_ADDR)));

    always_comb begin
        mem_we_d = 1'b0;
        mem_wa_d = wa;
        mem_wd_d = wd;
        if (clr_en) begin
            mem_we_d = 1'b1;
            mem_wa_d = clr_addr;
            mem_wd_d = '0;
        end else if (wr_acc) begin
            mem_we_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_wa_d] <= mem_wd_d;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra_lane;
        logic [XLEN-1:0] rd_lane;

        assign ra_lane = ra[i*AW +: AW];

        always_comb begin
            rd_lane = mem_q[ra_lane];
            if (busy) begin
                rd_lane = '0;
            end else if (ZERO_REG && (ra_lane == AW'(RF_ZERO_ADDR))) begin
                rd_lane = '0;
            end else if (BYPASS && wr_acc && (wa == ra_lane)) begin
                rd_lane = wd;
            end
        end

        assign rd[i*XLEN +: XLEN] = rd_lane;
    end

endmodule
